// File: rtl/alu_mc.sv
// Handshaked multi-cycle ALU: single-cycle logic/add/sub/compare ops and
// iterative radix-2 shift-add unsigned multiply, with registered result/flags.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// BUSY  | multiply iterating, one partial product per cycle
// DONE  | result valid, held until out_ready
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   result_q;
  logic               ovf_q, cout_q, zero_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               mulhi_q;

  logic               accept, is_mul, sub;
  logic [WIDTH-1:0]   bop, sum;
  logic [WIDTH:0]     sum_ext;
  logic               cout, ovf;
  logic [WIDTH-1:0]   sc_result_d;
  logic               sc_ovf_d, sc_cout_d;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   mul_result_d;
  logic               mul_cout_d;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mul    = (ALUop == 4'b1000) | (ALUop == 4'b1001);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign CarryOut  = cout_q;
  assign Zero      = zero_q;

  // Shared adder: subtraction is A + ~B + 1.
  assign sub     = (ALUop == 4'b0110) | (ALUop == 4'b0111) | (ALUop == 4'b0101);
  assign bop     = sub ? ~B : B;
  assign sum_ext = {1'b0, A} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
  assign sum     = sum_ext[WIDTH-1:0];
  assign cout    = sum_ext[WIDTH];
  assign ovf     = (A[WIDTH-1] == bop[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    sc_result_d = '0;
    sc_ovf_d    = 1'b0;
    sc_cout_d   = 1'b0;
    case (ALUop)
      4'b0000: sc_result_d = A & B;
      4'b0001: sc_result_d = A | B;
      4'b0011: sc_result_d = A ^ B;
      4'b0100: sc_result_d = ~(A | B);
      4'b0010: begin
        sc_result_d = sum;
        sc_ovf_d    = ovf;
        sc_cout_d   = cout;
      end
      4'b0110: begin
        sc_result_d = sum;
        sc_ovf_d    = ovf;
        sc_cout_d   = ~cout;
      end
      4'b0111: sc_result_d = {{(WIDTH-1){1'b0}}, ovf ^ sum[WIDTH-1]};
      4'b0101: sc_result_d = {{(WIDTH-1){1'b0}}, ~cout};
      default: sc_result_d = '0;
    endcase
  end

  // Upper half accumulates the multiplicand when the current multiplier LSB is set.
  assign add_hi       = prod_q[0] ? ({1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q})
                                  : {1'b0, prod_q[2*WIDTH-1:WIDTH]};
  assign prod_d       = {add_hi, prod_q[WIDTH-1:1]};
  assign mul_result_d = mulhi_q ? prod_d[2*WIDTH-1:WIDTH] : prod_d[WIDTH-1:0];
  assign mul_cout_d   = mulhi_q ? 1'b0 : (|prod_d[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mulhi_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (is_mul) begin
              state_q <= BUSY;
              mcand_q <= A;
              prod_q  <= {{WIDTH{1'b0}}, B};
              cnt_q   <= '0;
              mulhi_q <= ALUop[0];
            end else begin
              state_q  <= DONE;
              result_q <= sc_result_d;
              ovf_q    <= sc_ovf_d;
              cout_q   <= sc_cout_d;
              zero_q   <= (sc_result_d == '0);
            end
          end else if (state_q == DONE && out_ready) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q  <= DONE;
            result_q <= mul_result_d;
            ovf_q    <= 1'b0;
            cout_q   <= mul_cout_d;
            zero_q   <= (mul_result_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit instance for logic/add/compare ops and
// an 8-bit instance for the iterative multiply and mid-multiply reset.
module tb_alu_mc;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        rst32, in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  op32;
  logic        ov32, co32, z32;

  logic        rst8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  op8;
  logic        ov8, co8, z8;

  alu_mc #(.WIDTH(32)) u_alu32 (
    .clk(clk), .rst(rst32), .in_valid(in_valid32), .in_ready(in_ready32),
    .A(a32), .B(b32), .ALUop(op32), .out_valid(out_valid32), .out_ready(out_ready32),
    .Result(res32), .Overflow(ov32), .CarryOut(co32), .Zero(z32)
  );

  alu_mc #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .ALUop(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .Result(res8), .Overflow(ov8), .CarryOut(co8), .Zero(z8)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ov, output logic co,
                       output logic z, output int lat);
    op32 = op; a32 = a; b32 = b; in_valid32 = 1'b1; out_ready32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res32; ov = ov32; co = co32; z = z32;
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic [7:0] r, output logic co, output logic z, output int lat);
    op8 = op; a8 = a; b8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res8; co = co8; z = z8;
  endtask

  logic [31:0] r;
  logic [7:0]  r8;
  logic        ov, co, z;
  int          lat;
  logic        seen;

  initial begin
    rst32 = 1'b1; rst8 = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst32 = 1'b0; rst8 = 1'b0;
    check("rst_in_ready", in_ready32, 1);
    check("rst_out_valid", out_valid32, 0);
    check("rst_result", res32, 0);
    check("rst_zero", z32, 1);
    check("rst_flags", {ov32, co32}, 0);

    a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; op32 = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    check("idle_result", res32, 0);
    check("idle_out_valid", out_valid32, 0);

    // add/sub flags
    run32(4'b0010, 32'h7FFF_FFFF, 32'h1, r, ov, co, z, lat);
    check("add_ovf_lat", lat, 1);
    check("add_ovf_res", r, 32'h8000_0000);
    check("add_ovf_flags", {ov, co, z}, 3'b100);
    run32(4'b0010, 32'hFFFF_FFFF, 32'h1, r, ov, co, z, lat);
    check("add_wrap_res", r, 0);
    check("add_wrap_flags", {ov, co, z}, 3'b011);
    run32(4'b0110, 32'h0, 32'h1, r, ov, co, z, lat);
    check("sub_res", r, 32'hFFFF_FFFF);
    check("sub_flags", {ov, co, z}, 3'b010);

    // compares
    run32(4'b0111, 32'h8000_0000, 32'h1, r, ov, co, z, lat);
    check("slt_neg", r, 1);
    check("slt_flags", {ov, co}, 0);
    run32(4'b0101, 32'h8000_0000, 32'h1, r, ov, co, z, lat);
    check("sltu_big", r, 0);
    check("sltu_zero", z, 1);
    run32(4'b0111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, r, ov, co, z, lat);
    check("slt_pos_vs_neg", r, 0);
    run32(4'b0101, 32'h1, 32'h8000_0000, r, ov, co, z, lat);
    check("sltu_small", r, 1);

    // multiply on 8-bit instance
    run8(4'b1000, 8'hFF, 8'hFF, r8, co, z, lat);
    check("mullo_lat", lat, 9);
    check("mullo_res", r8, 8'h01);
    check("mullo_co", co, 1);
    check("mullo_ovf", ov8, 0);
    run8(4'b1001, 8'hFF, 8'hFF, r8, co, z, lat);
    check("mulhu_lat", lat, 9);
    check("mulhu_res", r8, 8'hFE);
    check("mulhu_co", co, 0);
    run8(4'b1000, 8'h03, 8'h05, r8, co, z, lat);
    check("mullo_small_res", r8, 8'h0F);
    check("mullo_small_co", co, 0);
    run8(4'b1001, 8'h03, 8'h05, r8, co, z, lat);
    check("mulhu_small_zero", {r8, z}, {8'h00, 1'b1});

    // back-pressure: result held while out_ready low
    @(posedge clk); #1;
    op32 = 4'b0010; a32 = 32'd5; b32 = 32'd6; in_valid32 = 1'b1; out_ready32 = 1'b0;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    a32 = 32'hDEAD_BEEF; b32 = 32'h1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid32, 1);
      check("bp_result", res32, 32'd11);
      check("bp_in_ready", in_ready32, 0);
      @(posedge clk); #1;
    end

    // streaming: consume and accept every cycle
    out_ready32 = 1'b1; in_valid32 = 1'b1;
    a32 = 32'hF0F0_1234; b32 = 32'h0FF0_FF00;
    op32 = 4'b0000;
    @(posedge clk); #1;
    check("stream_and_valid", out_valid32, 1);
    check("stream_and", res32, 32'h00F0_1200);
    op32 = 4'b0001;
    @(posedge clk); #1;
    check("stream_or_valid", out_valid32, 1);
    check("stream_or", res32, 32'hFFF0_FF34);
    op32 = 4'b0011;
    @(posedge clk); #1;
    check("stream_xor_valid", out_valid32, 1);
    check("stream_xor", res32, 32'hFF00_ED34);
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    check("stream_drain", out_valid32, 0);

    // reset in the middle of a multiply
    op8 = 4'b1000; a8 = 8'h07; b8 = 8'h09; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_valid", seen, 0);
    run8(4'b0010, 8'd2, 8'd3, r8, co, z, lat);
    check("post_abort_lat", lat, 1);
    check("post_abort_add", r8, 8'd5);

    // illegal opcode
    run32(4'b1111, 32'hFFFF, 32'h1, r, ov, co, z, lat);
    check("illegal_lat", lat, 1);
    check("illegal_res", r, 0);
    check("illegal_flags", {ov, co, z}, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked, multi-cycle successor to the single-cycle datapath ALU. It accepts one operation per valid/ready transfer and returns a registered result with Overflow/CarryOut/Zero flags. Logic and add/sub/compare ops complete in one cycle; unsigned multiply (low/high half) runs iteratively over WIDTH cycles. It sits between the decode/issue stage and writeback, so the core can stall on long operations.

## Interface
- WIDTH, 32: operand/result width; any integer ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALUop  in  4  operation code.
- out_valid  out  1  Result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- Result  out  WIDTH  registered result.
- Overflow  out  1  registered signed overflow.
- CarryOut  out  1  registered carry/borrow/high-nonzero flag.
- Zero  out  1  registered, equals (Result == 0).

## Operation
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT, 1000 MULLO, 1001 MULHU. All others are illegal: single-cycle, Result=0, Overflow=CarryOut=0, Zero=1.
- Add/sub core: sum = A + (sub ? ~B : B) + sub, where sub is set for SUB, SLT and SLTU; cout is the carry out of bit WIDTH-1.
- ADD: Result=sum, CarryOut=cout, Overflow=signed overflow.
- SUB: Result=sum, CarryOut=~cout (borrow), Overflow=signed overflow.
- SLT: Result=zero-extended (Overflow ^ sum[MSB]).
- SLTU: Result=zero-extended borrow.
- SLT/SLTU flags: Overflow=0, CarryOut=0.
- AND/OR/XOR/NOR: Overflow=CarryOut=0.
- MULLO/MULHU: unsigned 2·WIDTH product computed by radix-2 shift-add, one partial product per cycle. MULLO returns the low half and sets CarryOut=(high half != 0). MULHU returns the high half with CarryOut=0. Overflow=0 for both.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: multiply iterating, in_ready=0, out_valid=0, cycle counter 0..WIDTH-1.
  - DONE: out_valid=1, Result and flags held stable.
- Transitions:
  - IDLE→DONE on accept of a single-cycle op.
  - IDLE→BUSY on accept of a multiply.
  - BUSY→DONE when the counter reaches WIDTH-1.
  - DONE→IDLE on out_ready with no new accept.
  - DONE→DONE or DONE→BUSY on out_ready with a simultaneous accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back throughput is 1 op/cycle for single-cycle ops.
- Operands and opcode are captured only on accept (in_valid & in_ready). Input changes at any other time are ignored.
- In DONE with out_ready=0, all outputs hold indefinitely and in_ready=0.

## Timing
- Reset values: state=IDLE, in_ready=1 from the cycle after reset, out_valid=0, Result=0, Overflow=0, CarryOut=0, Zero=1. The multiply accumulator and counter are cleared.
- rst during BUSY or DONE aborts the operation, drops any pending result, and never raises out_valid for it.
- Single-cycle op accepted at edge E: out_valid=1 and Result valid after edge E. Latency 1.
- Multiply accepted at edge E: out_valid=1 after edge E+WIDTH. Latency WIDTH+1; no early termination.
- Result consumed at edge F (out_valid & out_ready):
  - With no simultaneous accept, out_valid=0 after F.
  - With a simultaneous single-cycle accept, out_valid stays 1 and the new result appears after F.
- Flags always change in the same cycle as Result.

## Test plan
- Reset then idle, WIDTH=32: hold rst for 2 cycles → in_ready=1, out_valid=0, Result=0, Zero=1. Changing A/B without in_valid leaves outputs unchanged.
- ADD/SUB flags, WIDTH=32:
  - ADD 0x7FFFFFFF+1 → Result 0x80000000, Overflow=1, CarryOut=0, 1-cycle latency.
  - ADD 0xFFFFFFFF+1 → Result 0, Zero=1, CarryOut=1.
  - SUB 0−1 → Result 0xFFFFFFFF, CarryOut=1, Overflow=0.
- Compares, WIDTH=32:
  - SLT 0x80000000 vs 1 → Result 1.
  - SLTU 0x80000000 vs 1 → Result 0.
  - SLT 0x7FFFFFFF vs 0xFFFFFFFF → Result 0.
- Multiply, WIDTH=8:
  - MULLO 0xFF×0xFF → Result 0x01, CarryOut=1, out_valid exactly 9 cycles after accept.
  - MULHU 0xFF×0xFF → Result 0xFE.
  - MULLO 3×5 → Result 0x0F, CarryOut=0.
- Back-pressure and streaming:
  - Hold out_ready=0 for 5 cycles after a result → Result stable, in_ready=0.
  - Then issue AND, OR, XOR back-to-back with out_ready=1 → one result per cycle, in order.
- Reset mid-multiply and illegal op:
  - Assert rst at cycle 4 of an 8-cycle multiply → out_valid never rises for it; a following ADD 2+3 returns 5.
  - Opcode 1111 → Result 0, Zero=1, Overflow=CarryOut=0.
